// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: jump encodings used by main control and the
// hazard unit, the nop instruction word, and the default reset PC.
package if_stage_pkg;

   // Decoder ID_jump encodings; 2'b11 is reserved and behaves as no jump.
   localparam logic [1:0] JMP_NONE = 2'b00;
   localparam logic [1:0] JMP_J    = 2'b01;
   localparam logic [1:0] JMP_JR   = 2'b10;

   // sll $0,$0,0 encodes as all zeros.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   // Clears the two byte-offset bits so every redirect lands word aligned.
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   // Source of the next PC value.
   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_HOLD,
      SEL_BR,
      SEL_J,
      SEL_JR
   } pc_sel_e;

   // Action applied to the IF/ID register on the coming edge.
   typedef enum logic [1:0] {
      IFID_LOAD,
      IFID_HOLD,
      IFID_FLUSH
   } ifid_ctl_e;

   // Pseudo-direct j/jal target: upper nibble of the delay PC, 26-bit index.
   function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [31:0] instr);
      return {pc4[31:28], instr[25:0], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC+4 and a
// valid flag. A flush inserts a nop bubble that is marked invalid so the
// decoder never acts on it.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  ifid_ctl_e   ctl_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   // Next contents: load a fresh fetch, keep the current one, or bubble.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      case (ctl_i)
         IFID_LOAD: begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
         end
         IFID_FLUSH: begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
         end
         default: begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
         end
      endcase
   end

   // Register update; reset leaves a nop bubble behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection between sequential
// fetch, EX branch redirect and ID jump redirect, the IF/ID register, and two
// saturating performance counters (stalled cycles, IF/ID flushes).
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             ex_br_taken,
   input  logic [31:0]      ex_br_target,
   input  logic [1:0]       id_jump,
   input  logic [31:0]      id_rs_value,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      IF_ID_instr,
   output logic [31:0]      IF_ID_pc4,
   output logic             IF_ID_valid,
   output logic [5:0]       ID_op,
   output logic [5:0]       ID_func,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      pc_plus4;
   logic [31:0]      br_target;
   logic [31:0]      jr_target;
   logic [31:0]      j_target;
   pc_sel_e          pc_sel;
   ifid_ctl_e        ifid_ctl;
   logic             stall_inc;
   logic             flush_inc;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Candidate next-PC values; PC+4 wraps naturally at 2^32.
   always_comb begin
      pc_plus4  = pc_q + 32'd4;
      br_target = ex_br_target & WORD_MASK;
      jr_target = id_rs_value & WORD_MASK;
      j_target  = jump_target(IF_ID_pc4, IF_ID_instr);
   end

   // Redirect priority: the older EX branch beats a stall, which beats an ID
   // jump. A stalled jump is simply re-examined once the stall drops, and an
   // invalid IF/ID entry (bubble) can never redirect.
   always_comb begin
      pc_sel    = SEL_SEQ;
      ifid_ctl  = IFID_LOAD;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (ex_br_taken) begin
         pc_sel    = SEL_BR;
         ifid_ctl  = IFID_FLUSH;
         flush_inc = 1'b1;
      end else if (stall) begin
         pc_sel    = SEL_HOLD;
         ifid_ctl  = IFID_HOLD;
         stall_inc = 1'b1;
      end else if (IF_ID_valid && (id_jump == JMP_J)) begin
         pc_sel    = SEL_J;
         ifid_ctl  = IFID_FLUSH;
         flush_inc = 1'b1;
      end else if (IF_ID_valid && (id_jump == JMP_JR)) begin
         pc_sel    = SEL_JR;
         ifid_ctl  = IFID_FLUSH;
         flush_inc = 1'b1;
      end
   end

   // Next PC multiplexer.
   always_comb begin
      pc_d = pc_plus4;
      case (pc_sel)
         SEL_HOLD: pc_d = pc_q;
         SEL_BR:   pc_d = br_target;
         SEL_J:    pc_d = j_target;
         SEL_JR:   pc_d = jr_target;
         default:  pc_d = pc_plus4;
      endcase
   end

   // Saturating counter increments; they stop at all-ones instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (flush_inc && (flush_cnt_q != CNT_MAX))
         flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   // PC and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .ctl_i   (ifid_ctl),
      .instr_i (imem_rdata),
      .pc4_i   (pc_plus4),
      .instr_o (IF_ID_instr),
      .pc4_o   (IF_ID_pc4),
      .valid_o (IF_ID_valid)
   );

   assign imem_addr    = pc_q;
   assign ID_op        = IF_ID_instr[31:26];
   assign ID_func      = IF_ID_instr[5:0];
   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, instruction-memory address drive, and the IF/ID pipeline register.
- Sits directly upstream of the main control decoder.
- Supplies ID_op and ID_func to the decoder.
- Consumes the decoder's ID_jump encoding to redirect on j/jal/jr, with jumps resolved in ID.
- Consumes EX-resolved branch outcomes.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
CNT_W, 16, width of saturating performance counters

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  load-use hold from hazard unit; freezes PC and IF/ID
ex_br_taken  in  1  branch in EX resolved taken
ex_br_target  in  32  branch target from EX
id_jump  in  2  decoder ID_jump: 00 none, 01 j/jal, 10 jr, 11 reserved (treated as none)
id_rs_value  in  32  forwarded rs value for jr
imem_addr  out  32  instruction memory address (= PC); memory is combinational read
imem_rdata  in  32  instruction word at imem_addr, same cycle
IF_ID_instr  out  32  registered instruction
IF_ID_pc4  out  32  registered PC+4 of that instruction
IF_ID_valid  out  1  1 = IF_ID_instr is a real fetched instruction
ID_op  out  6  IF_ID_instr[31:26]
ID_func  out  6  IF_ID_instr[5:0]
stall_cycles  out  CNT_W  count of cycles with stall applied
flush_count  out  CNT_W  count of IF/ID flushes

Behaviour:
Reset:
- rst sampled at posedge.
- PC <= RESET_PC.
- IF_ID_instr <= 0, which is a nop (sll $0,$0,0).
- IF_ID_pc4 <= 0; IF_ID_valid <= 0; both counters <= 0.
- Reset mid-operation discards all in-flight state the same cycle; no pending redirect survives.

Combinational:
- imem_addr = PC.
- ID_op and ID_func are direct slices of IF_ID_instr.
- pc4 = PC + 32'd4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- j target = {IF_ID_pc4[31:28], IF_ID_instr[25:0], 2'b00}.
- jr target = {id_rs_value[31:2], 2'b00}. Low bits are forced to 0; no misalignment trap.
- Branch target = {ex_br_target[31:2], 2'b00}.

Next-state priority, highest first, evaluated each posedge when rst=0:
1. ex_br_taken=1:
   - PC <= branch target.
   - IF/ID flushed: instr 0, pc4 0, valid 0.
   - flush_count++.
   - Overrides stall, because the older instruction wins, and overrides id_jump.
2. stall=1:
   - PC and IF/ID hold.
   - stall_cycles++.
   - A pending id_jump is not taken; it is re-evaluated once stall drops.
3. id_jump=01 and IF_ID_valid=1:
   - PC <= j target; IF/ID flushed; flush_count++.
4. id_jump=10 and IF_ID_valid=1:
   - PC <= jr target; IF/ID flushed; flush_count++.
5. Otherwise (normal):
   - PC <= pc4.
   - IF_ID_instr <= imem_rdata; IF_ID_pc4 <= pc4; IF_ID_valid <= 1.

General rules:
- No branch delay slot: the instruction fetched behind a taken jump or branch is squashed.
- id_jump is ignored when IF_ID_valid=0, so a flushed bubble never redirects.
- Counters saturate at all-ones and never wrap.
- Steady-state latency: an instruction fetched in cycle n is visible on IF_ID_* in cycle n+1.

Decomposition:
- Shared package: jump encodings JMP_NONE=2'b00, JMP_J=2'b01, JMP_JR=2'b10; NOP_INSTR=32'h0; RESET_PC default. These are shared with main control and the hazard unit.
- One natural sub-module, if_id_reg: the IF/ID register with hold/flush/load controls plus the valid bit.
- PC/next-PC logic and the counters stay in if_stage.

Test Plan:
- Reset then 3 normal cycles, imem returning 32'h2008_0005, 32'h2009_0003, 32'h0109_5020:
  - PC sequence 3000 → 3004 → 3008 → 300C.
  - IF_ID_instr follows one cycle later.
  - ID_op = 6'b001000, then 6'b001000, then ID_func = 6'b100000.
- IF_ID holding j with instr[25:0]=26'h0000C40 and pc4=32'h0000_3008, id_jump=01:
  - next PC = 32'h0000_3100.
  - IF_ID_valid=0 for one cycle; flush_count=1.
- jr with id_rs_value=32'h0000_3047:
  - next PC = 32'h0000_3044; IF/ID flushed.
- stall=1 for 2 cycles:
  - PC and IF_ID_instr unchanged; stall_cycles=2.
  - After release, fetch resumes at the held PC.
- Same cycle ex_br_taken=1 (target 32'h0000_3200), stall=1 and id_jump=01:
  - PC = 32'h0000_3200; IF/ID flushed.
  - stall_cycles unchanged; flush_count increments by 1.
- rst asserted mid-stream while a jump is pending in ID:
  - PC = RESET_PC; IF_ID_valid=0; counters 0; no redirect occurs after rst drops.
- PC forced near top (RESET_PC=32'hFFFF_FFFC):
  - next PC = 0.
- Counter saturation with CNT_W=4:
  - 20 stall cycles → stall_cycles = 4'hF.
